// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcode/funct
// values and the datapath mux/ALU select encodings.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ORIEX   = 4'd10,
    S_IMMWB   = 4'd11,
    S_JUMP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// R-type funct decoder: maps funct to the ALU operation and flags unsupported
// funct codes (which fall back to add).
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       illegal_funct
);

  // funct lookup
  always_comb begin
    alucontrol    = ALU_ADD;
    illegal_funct = 1'b0;
    case (funct)
      FUNCT_ADD: alucontrol = ALU_ADD;
      FUNCT_SUB: alucontrol = ALU_SUB;
      FUNCT_AND: alucontrol = ALU_AND;
      FUNCT_OR:  alucontrol = ALU_OR;
      FUNCT_SLT: alucontrol = ALU_SLT;
      default: begin
        alucontrol    = ALU_ADD;
        illegal_funct = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore-style control FSM for a multicycle MIPS datapath. Outputs decode from the
// state and the IR fields; pcen also folds in the ALU zero flag for beq.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       extsel,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  state_t     state_r;
  state_t     state_next_s;
  logic [2:0] alu_funct_s;
  logic       illegal_funct_s;
  logic       pcwrite_s;
  logic       branch_s;
  logic       memwrite_s;
  logic       irwrite_s;
  logic       regwrite_s;

  alu_decoder u_alu_decoder (
    .funct         (funct),
    .alucontrol    (alu_funct_s),
    .illegal_funct (illegal_funct_s)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next-state and per-state output decode
  always_comb begin
    state_next_s = S_FETCH;
    pcwrite_s    = 1'b0;
    branch_s     = 1'b0;
    memwrite_s   = 1'b0;
    irwrite_s    = 1'b0;
    regwrite_s   = 1'b0;
    iord         = 1'b0;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = SRCB_RD2;
    extsel       = 1'b0;
    pcsrc        = PCSRC_ALU;
    alucontrol   = ALU_ADD;
    illegal      = 1'b0;
    case (state_r)
      S_FETCH: begin
        alusrcb      = SRCB_FOUR;
        irwrite_s    = 1'b1;
        pcwrite_s    = 1'b1;
        state_next_s = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = SRCB_IMMSH;
        case (op)
          OP_LW, OP_SW: state_next_s = S_MEMADR;
          OP_RTYPE:     state_next_s = S_EXECUTE;
          OP_BEQ:       state_next_s = S_BRANCH;
          OP_ADDI:      state_next_s = S_ADDIEX;
          OP_ORI:       state_next_s = S_ORIEX;
          OP_J:         state_next_s = S_JUMP;
          default: begin
            state_next_s = S_FETCH;
            illegal      = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        case (op)
          OP_LW:   state_next_s = S_MEMRD;
          OP_SW:   state_next_s = S_MEMWR;
          default: state_next_s = S_FETCH;
        endcase
      end
      S_MEMRD: begin
        iord         = 1'b1;
        state_next_s = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = alu_funct_s;
        illegal    = illegal_funct_s;
        if (illegal_funct_s) begin
          state_next_s = S_FETCH;
        end else begin
          state_next_s = S_ALUWB;
        end
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = PCSRC_ALUOUT;
        branch_s   = 1'b1;
      end
      S_ADDIEX: begin
        alusrca      = 1'b1;
        alusrcb      = SRCB_IMM;
        state_next_s = S_IMMWB;
      end
      S_ORIEX: begin
        alusrca      = 1'b1;
        alusrcb      = SRCB_IMM;
        extsel       = 1'b1;
        alucontrol   = ALU_OR;
        state_next_s = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite_s = 1'b1;
      end
      S_JUMP: begin
        pcsrc     = PCSRC_JUMP;
        pcwrite_s = 1'b1;
      end
      default: begin
        state_next_s = S_FETCH;
      end
    endcase
  end

  // reset sits in FETCH, whose strobes must not fire until reset releases
  always_comb begin
    if (!reset) begin
      pcen     = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
    end else begin
      pcen     = pcwrite_s | (branch_s & zero);
      memwrite = memwrite_s;
      irwrite  = irwrite_s;
      regwrite = regwrite_s;
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameters: none; all encodings come from the shared package.
REQ-002 clk  input  1  rising-edge clock for the state register.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 op  input  6  instr[31:26] from the instruction register.
REQ-005 funct  input  6  instr[5:0] from the instruction register.
REQ-006 zero  input  1  ALU result-equals-zero flag.
REQ-007 pcen  output  1  PC register write enable.
REQ-008 memwrite  output  1  data memory write strobe.
REQ-009 irwrite  output  1  instruction register load.
REQ-010 regwrite  output  1  register file we3.
REQ-011 iord  output  1  memory address select (0 = PC, 1 = ALUOut).
REQ-012 memtoreg  output  1  register write data select (1 = memory data).
REQ-013 regdst  output  1  write address select (1 = rd, 0 = rt).
REQ-014 alusrca  output  1  ALU A select (0 = PC, 1 = rd1).
REQ-015 alusrcb  output  2  ALU B select: 00 rd2, 01 const 4, 10 extended imm, 11 sign imm << 2.
REQ-016 extsel  output  1  immediate extension select (0 = sign extension, 1 = zero extension).
REQ-017 pcsrc  output  2  next-PC select: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-018 alucontrol  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-019 illegal  output  1  one-cycle pulse when an unsupported op or funct is decoded.

Function
REQ-020 The block SHALL be a Moore FSM; all outputs are decoded from the state and registered IR fields only, except pcen.
REQ-021 pcen SHALL equal pcwrite OR (branch AND zero), where pcwrite and branch are internal state-decoded terms.
REQ-022 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ORIEX, IMMWB, JUMP.
REQ-023 FETCH: iord=0, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=00, irwrite=1, pcwrite=1; next state DECODE.
REQ-024 DECODE: alusrca=0, alusrcb=11, alucontrol=add. Next state by op:
  - lw/sw (100011/101011) -> MEMADR
  - R-type (000000) -> EXECUTE
  - beq (000100) -> BRANCH
  - addi (001000) -> ADDIEX
  - ori (001101) -> ORIEX
  - j (000010) -> JUMP
  - any other op -> FETCH, with illegal asserted in DECODE.
REQ-025 MEMADR: alusrca=1, alusrcb=10, extsel=0, alucontrol=add; next MEMRD for lw, MEMWR for sw.
REQ-026 MEMRD: iord=1; next MEMWB.
REQ-027 MEMWB: regdst=0, memtoreg=1, regwrite=1; next FETCH.
REQ-028 MEMWR: iord=1, memwrite=1; next FETCH.
REQ-029 EXECUTE: alusrca=1, alusrcb=00, alucontrol decoded from funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt
  - any other funct: alucontrol=add, illegal asserted, next FETCH (ALUWB skipped).
  Legal funct: next ALUWB.
REQ-030 ALUWB: regdst=1, memtoreg=0, regwrite=1; next FETCH.
REQ-031 BRANCH: alusrca=1, alusrcb=00, alucontrol=sub, pcsrc=01, branch=1; next FETCH.
REQ-032 ADDIEX: alusrca=1, alusrcb=10, extsel=0, alucontrol=add; next IMMWB.
REQ-033 ORIEX: alusrca=1, alusrcb=10, extsel=1, alucontrol=or; next IMMWB.
REQ-034 IMMWB: regdst=0, memtoreg=0, regwrite=1; next FETCH.
REQ-035 JUMP: pcsrc=10, pcwrite=1; next FETCH.
REQ-036 Every unlisted output in every state SHALL be 0 (alusrcb=00, pcsrc=00, alucontrol=010).
REQ-037 Cycles per instruction SHALL be fixed: lw 5; sw, R-type, addi, ori 4; beq, j 3; illegal 2.
REQ-038 Unreachable state encodings SHALL transition to FETCH with all strobes low.

Reset
REQ-039 While reset=0, the state SHALL be FETCH, asynchronously, including mid-instruction; no write strobe (memwrite, regwrite, irwrite, pcen) may assert during reset.
REQ-040 The first rising clk edge after reset deasserts SHALL perform a FETCH (PC += 4, IR load).

Structure
REQ-041 A shared package SHALL hold the state enum, op and funct constants, and the alucontrol, alusrcb and pcsrc encodings.
REQ-042 One sub-module, alu_decoder (funct -> alucontrol, illegal_funct), SHALL be instantiated; state register and next-state/output logic stay in multicycle_ctrl.

Verification
REQ-043 Reset low 3 cycles, then op=100011 (lw) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5.
REQ-044 op=000000, funct=101010 -> alucontrol=111 in EXECUTE, regwrite=1 and regdst=1 in ALUWB, back to FETCH after 4 cycles.
REQ-045 op=000100 with zero=1 in BRANCH -> pcen=1, pcsrc=01; repeat with zero=0 -> pcen=0; both return to FETCH.
REQ-046 op=001101 (ori) -> extsel=1 and alucontrol=001 in ORIEX, regwrite=1 and regdst=0 in IMMWB.
REQ-047 op=111111 -> illegal=1 for exactly one cycle in DECODE, no write strobe, FETCH next; reset=0 asserted in MEMRD -> FETCH immediately with regwrite=0.
